// File: rtl/mesi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mesi_bus_arbiter
//   Snoop-bus arbiter/sequencer for NUM_MASTERS MESI cache controllers that
//   share one bus. A requester is picked round-robin. Its command is broadcast
//   as a snoop to every other cache, and their shared/dirty responses are
//   collected. Memory is fetched when no cache supplies the line. A one-cycle
//   completion carrying the combined result is then returned to the winner.
//
//   Optional feature macro: MESI_ARB_TIMEOUT_EN
//     When defined, COLLECT gives up after SNOOP_TIMEOUT cycles and completes
//     with resp_err=1. When undefined, COLLECT waits for every ack.
// -----------------------------------------------------------------------------
module mesi_bus_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int ADDR_W        = 20,
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [2*NUM_MASTERS-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_MASTERS-1:0] req_addr,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          snoop_valid,
  output logic [1:0]                    snoop_cmd,
  output logic [ADDR_W-1:0]             snoop_addr,
  output logic [NUM_MASTERS-1:0]        snoop_target,
  input  logic [NUM_MASTERS-1:0]        snoop_ack,
  input  logic [NUM_MASTERS-1:0]        snoop_shared,
  input  logic [NUM_MASTERS-1:0]        snoop_dirty,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  output logic                          done,
  output logic                          resp_shared,
  output logic                          resp_dirty,
  output logic                          resp_err
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_RSVD = 2'b11
  } bus_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_COLLECT,
    S_MEM,
    S_DONE
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         ptr;        // round-robin search start
  logic [IDX_W-1:0]         owner;      // index of the current grant
  logic [NUM_MASTERS-1:0]   ack_seen;
  logic [NUM_MASTERS-1:0]   shared_acc;
  logic [NUM_MASTERS-1:0]   dirty_acc;

`ifdef MESI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(SNOOP_TIMEOUT + 1);
  logic [TMO_W-1:0]         tmo_cnt;
`endif

  // Winner selection: first set req at or after ptr, wrapping modulo NUM_MASTERS.
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W:0]           scan_idx;
  logic [NUM_MASTERS-1:0]   win_onehot;
  logic [1:0]               win_cmd;
  logic [ADDR_W-1:0]        win_addr;

  // Round-robin scan. The loop runs downwards, so the nearest requester is the one kept.
  always_comb begin
    // NOTE: every variable written here gets a default first; otherwise a path that skips the assignment infers a latch.
    win_idx  = ptr;
    scan_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (scan_idx >= (IDX_W + 1)'(NUM_MASTERS))
        scan_idx = scan_idx - (IDX_W + 1)'(NUM_MASTERS);
      if (req[scan_idx[IDX_W-1:0]])
        win_idx = scan_idx[IDX_W-1:0];
    end
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    win_cmd             = req_cmd[int'(win_idx)*2 +: 2];
    win_addr            = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  end

  // Snoop response accumulation, including the acks that arrive this cycle.
  logic [NUM_MASTERS-1:0]   ack_valid;
  logic [NUM_MASTERS-1:0]   ack_now;
  logic [NUM_MASTERS-1:0]   shared_now;
  logic [NUM_MASTERS-1:0]   dirty_now;
  logic                     collect_done;

  // Acks are masked by snoop_target, so any ack on the owner bit is dropped.
  always_comb begin
    ack_valid    = snoop_ack & snoop_target;
    ack_now      = ack_seen   | ack_valid;
    shared_now   = shared_acc | (ack_valid & snoop_shared);
    dirty_now    = dirty_acc  | (ack_valid & snoop_dirty);
    collect_done = &(ack_now | grant);
  end

  // Transaction sequencer. Every output is driven from a register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      owner        <= '0;
      ack_seen     <= '0;
      shared_acc   <= '0;
      dirty_acc    <= '0;
      grant        <= '0;
      snoop_valid  <= 1'b0;
      snoop_cmd    <= '0;
      snoop_addr   <= '0;
      snoop_target <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      done         <= 1'b0;
      resp_shared  <= 1'b0;
      resp_dirty   <= 1'b0;
      resp_err     <= 1'b0;
`ifdef MESI_ARB_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant        <= win_onehot;
            snoop_target <= ~win_onehot;
            owner        <= win_idx;
            snoop_cmd    <= win_cmd;
            snoop_addr   <= win_addr;
            if (win_cmd == BUS_RSVD) begin
              // A reserved command is never put on the bus.
              done        <= 1'b1;
              resp_err    <= 1'b1;
              resp_shared <= 1'b0;
              resp_dirty  <= 1'b0;
              state       <= S_DONE;
            end else begin
              snoop_valid <= 1'b1;
              state       <= S_SNOOP;
            end
          end
        end

        S_SNOOP: begin
          snoop_valid <= 1'b0;
          ack_seen    <= '0;
          shared_acc  <= '0;
          dirty_acc   <= '0;
`ifdef MESI_ARB_TIMEOUT_EN
          tmo_cnt     <= '0;
`endif
          state       <= S_COLLECT;
        end

        S_COLLECT: begin
          ack_seen   <= ack_now;
          shared_acc <= shared_now;
          dirty_acc  <= dirty_now;
          if (collect_done) begin
            if (snoop_cmd == BUS_UPGR || |dirty_now) begin
              // An upgrade needs no data, and a dirty snooper supplies it.
              done        <= 1'b1;
              resp_shared <= |shared_now;
              resp_dirty  <= |dirty_now;
              resp_err    <= 1'b0;
              state       <= S_DONE;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= snoop_addr;
              state    <= S_MEM;
            end
          end
`ifdef MESI_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(SNOOP_TIMEOUT - 1)) begin
            done        <= 1'b1;
            resp_err    <= 1'b1;
            resp_shared <= 1'b0;
            resp_dirty  <= 1'b0;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        S_MEM: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            done        <= 1'b1;
            resp_shared <= |shared_acc;
            resp_dirty  <= 1'b0;
            resp_err    <= 1'b0;
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          done         <= 1'b0;
          resp_shared  <= 1'b0;
          resp_dirty   <= 1'b0;
          resp_err     <= 1'b0;
          grant        <= '0;
          snoop_target <= '0;
          ptr          <= (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mesi_bus_arbiter
//   Directed bench for mesi_bus_arbiter (4 masters, 20-bit addresses).
//   Inputs change on the falling edge and outputs are sampled on the falling
//   edge. The DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_mesi_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 20;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_cmd;
  logic [AW*N-1:0] req_addr;
  logic [N-1:0]    grant;
  logic            snoop_valid;
  logic [1:0]      snoop_cmd;
  logic [AW-1:0]   snoop_addr;
  logic [N-1:0]    snoop_target;
  logic [N-1:0]    snoop_ack;
  logic [N-1:0]    snoop_shared;
  logic [N-1:0]    snoop_dirty;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ack;
  logic            done;
  logic            resp_shared;
  logic            resp_dirty;
  logic            resp_err;

  int errors = 0;
  int checks = 0;

  bit ok;
  bit saw_sv;
  bit saw_mem;
  int cycles;

  mesi_bus_arbiter #(
    .NUM_MASTERS  (N),
    .ADDR_W       (AW),
    .SNOOP_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_cmd     (req_cmd),
    .req_addr    (req_addr),
    .grant       (grant),
    .snoop_valid (snoop_valid),
    .snoop_cmd   (snoop_cmd),
    .snoop_addr  (snoop_addr),
    .snoop_target(snoop_target),
    .snoop_ack   (snoop_ack),
    .snoop_shared(snoop_shared),
    .snoop_dirty (snoop_dirty),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .done        (done),
    .resp_shared (resp_shared),
    .resp_dirty  (resp_dirty),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [1:0] cmd, input logic [AW-1:0] addr);
    req[m]              = 1'b1;
    req_cmd[m*2 +: 2]   = cmd;
    req_addr[m*AW +: AW] = addr;
  endtask

  // Advances falling edges until done, recording whether a snoop or a memory fetch was seen.
  task automatic wait_done(output bit got, output int n, output bit sv, output bit mr);
    got = 1'b0;
    n   = 0;
    sv  = 1'b0;
    mr  = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (snoop_valid) sv = 1'b1;
      if (mem_req)     mr = 1'b1;
      if (done) begin
        got = 1'b1;
        n   = i;
        break;
      end
    end
  endtask

  task automatic idle_inputs();
    req          = '0;
    snoop_ack    = '0;
    snoop_shared = '0;
    snoop_dirty  = '0;
    mem_ack      = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst      = 1'b1;
    req_cmd  = '0;
    req_addr = '0;
    idle_inputs();

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_grant",       32'(grant),       32'h0);
    check("rst_snoop_valid", 32'(snoop_valid), 32'h0);
    check("rst_done",        32'(done),        32'h0);
    check("rst_mem_req",     32'(mem_req),     32'h0);
    check("rst_resp_err",    32'(resp_err),    32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_grant", 32'(grant), 32'h0);

    // ---------------- T3: all requesting, round-robin order ----------------
    for (int m = 0; m < N; m++) set_req(m, 2'b10, AW'(32'h00100 + m));
    snoop_ack = 4'hF;
    for (int t = 0; t < 5; t++) begin
      wait_done(ok, cycles, saw_sv, saw_mem);
      check($sformatf("t3_done_%0d", t),  32'(ok),         32'h1);
      check($sformatf("t3_grant_%0d", t), 32'(grant),      32'h1 << exp_order[t]);
      check($sformatf("t3_addr_%0d", t),  32'(snoop_addr), 32'h00100 + exp_order[t]);
    end
    idle_inputs();
    repeat (2) @(negedge clk);

    // ---------------- T2: BUS_RD m0, no sharers, memory fetch ----------------
    set_req(0, 2'b00, 20'h81000);
    @(negedge clk);  // SNOOP
    check("t2_grant",        32'(grant),        32'h1);
    check("t2_snoop_valid",  32'(snoop_valid),  32'h1);
    check("t2_snoop_cmd",    32'(snoop_cmd),    32'h0);
    check("t2_snoop_addr",   32'(snoop_addr),   32'h81000);
    check("t2_snoop_target", 32'(snoop_target), 32'hE);
    @(negedge clk);  // COLLECT
    check("t2_snoop_valid_1cyc", 32'(snoop_valid), 32'h0);
    snoop_ack = 4'b1110;
    @(negedge clk);  // MEM
    snoop_ack = '0;
    check("t2_mem_req",  32'(mem_req),  32'h1);
    check("t2_mem_addr", 32'(mem_addr), 32'h81000);
    check("t2_no_done",  32'(done),     32'h0);
    @(negedge clk);  // still MEM
    check("t2_mem_req_held", 32'(mem_req), 32'h1);
    mem_ack = 1'b1;
    @(negedge clk);  // DONE
    check("t2_done",        32'(done),        32'h1);
    check("t2_resp_shared", 32'(resp_shared), 32'h0);
    check("t2_resp_dirty",  32'(resp_dirty),  32'h0);
    check("t2_mem_req_off", 32'(mem_req),     32'h0);
    idle_inputs();
    @(negedge clk);  // IDLE
    check("t2_grant_clear", 32'(grant), 32'h0);
    check("t2_done_1cyc",   32'(done),  32'h0);
    @(negedge clk);

    // ---------------- T1: reset in COLLECT, pointer restarts at 0 ----------------
    set_req(2, 2'b00, 20'h12345);
    @(negedge clk);  // SNOOP
    check("t1_grant", 32'(grant), 32'h4);
    @(negedge clk);  // COLLECT
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    check("t1_rst_grant",       32'(grant),       32'h0);
    check("t1_rst_done",        32'(done),        32'h0);
    check("t1_rst_snoop_valid", 32'(snoop_valid), 32'h0);
    check("t1_rst_mem_req",     32'(mem_req),     32'h0);
    rst = 1'b0;
    set_req(0, 2'b00, 20'h81000);
    set_req(3, 2'b00, 20'h33333);
    @(negedge clk);  // SNOOP
    check("t1_restart_grant", 32'(grant), 32'h1);
    snoop_ack   = 4'b1110;
    snoop_dirty = 4'b0010;
    wait_done(ok, cycles, saw_sv, saw_mem);
    check("t1_done",       32'(ok),         32'h1);
    check("t1_resp_dirty", 32'(resp_dirty), 32'h1);
    check("t1_no_mem",     32'(saw_mem),    32'h0);
    idle_inputs();
    repeat (2) @(negedge clk);

    // ---------------- T4: BUS_RDX m2 with dirty supplier, BUS_UPGR m3 ----------------
    set_req(2, 2'b01, 20'h0ABCD);
    snoop_ack   = 4'b1011;
    snoop_dirty = 4'b0010;
    wait_done(ok, cycles, saw_sv, saw_mem);
    check("t4_rdx_done",        32'(ok),          32'h1);
    check("t4_rdx_grant",       32'(grant),       32'h4);
    check("t4_rdx_no_mem",      32'(saw_mem),     32'h0);
    check("t4_rdx_resp_dirty",  32'(resp_dirty),  32'h1);
    check("t4_rdx_resp_shared", 32'(resp_shared), 32'h0);
    idle_inputs();
    repeat (2) @(negedge clk);

    set_req(3, 2'b10, 20'h00F00);
    snoop_ack = 4'b0111;
    wait_done(ok, cycles, saw_sv, saw_mem);
    check("t4_upgr_done",       32'(ok),         32'h1);
    check("t4_upgr_grant",      32'(grant),      32'h8);
    check("t4_upgr_no_mem",     32'(saw_mem),    32'h0);
    check("t4_upgr_resp_dirty", 32'(resp_dirty), 32'h0);
    check("t4_upgr_latency",    32'(cycles),     32'd3);
    idle_inputs();
    repeat (2) @(negedge clk);

    // ---------------- T5: BUS_RD m1, m0 acks shared two cycles late ----------------
    set_req(1, 2'b00, 20'h55555);
    @(negedge clk);  // SNOOP
    check("t5_grant", 32'(grant), 32'h2);
    @(negedge clk);  // COLLECT
    snoop_ack = 4'b1100;
    @(negedge clk);
    snoop_ack = '0;
    check("t5_wait_done_a", 32'(done),    32'h0);
    check("t5_wait_mem_a",  32'(mem_req), 32'h0);
    @(negedge clk);
    check("t5_wait_done_b", 32'(done),    32'h0);
    check("t5_wait_mem_b",  32'(mem_req), 32'h0);
    snoop_ack    = 4'b0001;
    snoop_shared = 4'b0001;
    @(negedge clk);  // MEM
    snoop_ack    = '0;
    snoop_shared = '0;
    check("t5_mem_req", 32'(mem_req), 32'h1);
    check("t5_no_done", 32'(done),    32'h0);
    mem_ack = 1'b1;
    @(negedge clk);  // DONE
    check("t5_done",        32'(done),        32'h1);
    check("t5_resp_shared", 32'(resp_shared), 32'h1);
    check("t5_resp_dirty",  32'(resp_dirty),  32'h0);
    idle_inputs();
    repeat (2) @(negedge clk);

    // ---------------- T6: reserved command ----------------
    set_req(2, 2'b11, 20'h0BEEF);
    wait_done(ok, cycles, saw_sv, saw_mem);
    check("t6_done",     32'(ok),       32'h1);
    check("t6_latency",  32'(cycles),   32'd1);
    check("t6_no_snoop", 32'(saw_sv),   32'h0);
    check("t6_no_mem",   32'(saw_mem),  32'h0);
    check("t6_resp_err", 32'(resp_err), 32'h1);
    check("t6_grant",    32'(grant),    32'h4);
    idle_inputs();
    repeat (2) @(negedge clk);

`ifdef MESI_ARB_TIMEOUT_EN
    // ---------------- T6b: m3 never acks, snoop timeout ----------------
    set_req(1, 2'b00, 20'h77777);
    snoop_ack    = 4'b0101;
    snoop_shared = 4'b0101;
    wait_done(ok, cycles, saw_sv, saw_mem);
    check("t6_tmo_done",        32'(ok),          32'h1);
    check("t6_tmo_latency",     32'(cycles),      32'd18);
    check("t6_tmo_resp_err",    32'(resp_err),    32'h1);
    check("t6_tmo_resp_shared", 32'(resp_shared), 32'h0);
    check("t6_tmo_no_mem",      32'(saw_mem),     32'h0);
    idle_inputs();
    repeat (2) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
